// File: rtl/bioee_pkg.sv
// Shared encodings for the sweep sequencer: FSM states, sweep direction and default code width.
package bioee_pkg;

    localparam int CODE_W_DEF = 8;

    typedef enum logic [3:0] {
        S_IDLE   = 4'd0,
        S_WR     = 4'd1,
        S_WAIT_D = 4'd2,
        S_SET    = 4'd3,
        S_WAIT_S = 4'd4,
        S_DWELL  = 4'd5,
        S_SAMPLE = 4'd6,
        S_STEP   = 4'd7,
        S_FIN    = 4'd8
    } state_e;

    typedef enum logic {
        DIR_UP = 1'b0,
        DIR_DN = 1'b1
    } dir_e;

endpackage

// File: rtl/bioee_sweep_step.sv
// Next-point logic for the triangular sweep: step, clamp to the window and turn around.
// Purely combinational; each leg includes both of its endpoints, so turnaround points are visited twice.
import bioee_pkg::*;

module bioee_sweep_step #(
    parameter int CODE_W = CODE_W_DEF
) (
    input  logic [CODE_W-1:0] code_i,
    input  logic [CODE_W-1:0] step_i,
    input  logic [CODE_W-1:0] lo_i,
    input  logic [CODE_W-1:0] hi_i,
    input  dir_e              dir_i,
    input  logic              last_cycle_i,
    output logic [CODE_W-1:0] code_o,
    output dir_e              dir_o,
    output logic              cyc_inc_o,
    output logic              fin_o
);

    logic [CODE_W:0] sum;
    logic [CODE_W:0] diff;

    assign sum  = {1'b0, code_i} + {1'b0, step_i};
    assign diff = {1'b0, code_i} - {1'b0, step_i};

    always_comb begin
        code_o    = code_i;
        dir_o     = dir_i;
        cyc_inc_o = 1'b0;
        fin_o     = 1'b0;
        if (dir_i == DIR_UP) begin
            // Sitting on hi already: repeat the point as the first of the down leg.
            if (code_i == hi_i) begin
                dir_o = DIR_DN;
            end else if (sum >= {1'b0, hi_i}) begin
                code_o = hi_i;
            end else begin
                code_o = sum[CODE_W-1:0];
            end
        end else begin
            if (code_i == lo_i) begin
                cyc_inc_o = 1'b1;
                fin_o     = last_cycle_i;
                dir_o     = DIR_UP;
            end else if (diff[CODE_W] || (diff[CODE_W-1:0] <= lo_i)) begin
                code_o = lo_i;
            end else begin
                code_o = diff[CODE_W-1:0];
            end
        end
    end

endmodule

// File: rtl/bioee_sweep_sequencer.sv
// Triangular DAC sweep sequencer: write code, load DAC, dwell, strobe ADC, step; repeats for cfg_cycles.
// Latency: per point 2 + ack delays + cfg_dwell clks to adc_sample; ack waits are unbounded unless
// BIOEE_SWEEP_ACK_TIMEOUT_EN is defined, in which case an ack missing for ACK_TO clks sets err and idles.
import bioee_pkg::*;

module bioee_sweep_sequencer #(
    parameter int          CODE_W  = CODE_W_DEF,
    parameter int          DWELL_W = 16,
    parameter int          CYC_W   = 8,
    parameter int unsigned ACK_TO  = 1024
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               start,
    input  logic               abort,
    input  logic [CODE_W-1:0]  cfg_lo,
    input  logic [CODE_W-1:0]  cfg_hi,
    input  logic [CODE_W-1:0]  cfg_step,
    input  logic [DWELL_W-1:0] cfg_dwell,
    input  logic [CYC_W-1:0]   cfg_cycles,
    output logic [CODE_W-1:0]  dac_code,
    output logic               dac_write,
    output logic               dac_set,
    input  logic               dac_ack_data,
    input  logic               dac_ack_set,
    output logic               adc_sample,
    output logic               busy,
    output logic               done,
    output logic               err,
    output logic [CYC_W-1:0]   cycle_cnt
);

    state_e             state_q;
    dir_e               dir_q, dir_d;
    logic [CODE_W-1:0]  code_q, code_d, lo_q, hi_q, step_q;
    logic [DWELL_W-1:0] dwell_q, dwell_cnt_q;
    logic [CYC_W-1:0]   cycles_q, cyc_cnt_q;
    logic               dac_write_q, dac_set_q, adc_sample_q, done_q;
    logic               cyc_inc, fin, last_cycle;
    logic [CODE_W-1:0]  lo_sw, hi_sw;

    assign lo_sw      = (cfg_lo > cfg_hi) ? cfg_hi : cfg_lo;
    assign hi_sw      = (cfg_lo > cfg_hi) ? cfg_lo : cfg_hi;
    assign last_cycle = ((cyc_cnt_q + CYC_W'(1)) == cycles_q);

    bioee_sweep_step #(.CODE_W(CODE_W)) u_step (
        .code_i       (code_q),
        .step_i       (step_q),
        .lo_i         (lo_q),
        .hi_i         (hi_q),
        .dir_i        (dir_q),
        .last_cycle_i (last_cycle),
        .code_o       (code_d),
        .dir_o        (dir_d),
        .cyc_inc_o    (cyc_inc),
        .fin_o        (fin)
    );

`ifdef BIOEE_SWEEP_ACK_TIMEOUT_EN
    localparam int TO_W = $clog2(ACK_TO) + 1;
    logic [TO_W-1:0] to_q;
    logic            err_q;
    assign err = err_q;
`else
    logic unused_ack_to;
    assign unused_ack_to = (ACK_TO == 0);
    assign err = 1'b0;
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= S_IDLE;
            dir_q        <= DIR_UP;
            code_q       <= '0;
            lo_q         <= '0;
            hi_q         <= '0;
            step_q       <= '0;
            dwell_q      <= '0;
            dwell_cnt_q  <= '0;
            cycles_q     <= '0;
            cyc_cnt_q    <= '0;
            dac_write_q  <= 1'b0;
            dac_set_q    <= 1'b0;
            adc_sample_q <= 1'b0;
            done_q       <= 1'b0;
`ifdef BIOEE_SWEEP_ACK_TIMEOUT_EN
            to_q         <= '0;
            err_q        <= 1'b0;
`endif
        end else begin
            dac_write_q  <= 1'b0;
            dac_set_q    <= 1'b0;
            adc_sample_q <= 1'b0;
            done_q       <= 1'b0;
`ifdef BIOEE_SWEEP_ACK_TIMEOUT_EN
            // Counter only survives a cycle spent waiting for an ack.
            to_q         <= '0;
`endif
            if (abort && (state_q != S_IDLE)) begin
                state_q <= S_IDLE;
            end else begin
                case (state_q)
                    S_IDLE: if (start && !abort) begin
                        lo_q        <= lo_sw;
                        hi_q        <= hi_sw;
                        code_q      <= lo_sw;
                        step_q      <= (cfg_step == '0) ? CODE_W'(1) : cfg_step;
                        cycles_q    <= (cfg_cycles == '0) ? CYC_W'(1) : cfg_cycles;
                        dwell_q     <= cfg_dwell;
                        dir_q       <= DIR_UP;
                        cyc_cnt_q   <= '0;
`ifdef BIOEE_SWEEP_ACK_TIMEOUT_EN
                        err_q       <= 1'b0;
`endif
                        dac_write_q <= 1'b1;
                        state_q     <= S_WR;
                    end
                    S_WR, S_WAIT_D: begin
                        if (dac_ack_data) begin
                            dac_set_q <= 1'b1;
                            state_q   <= S_SET;
                        end else if (state_q == S_WR) begin
                            state_q <= S_WAIT_D;
                        end
`ifdef BIOEE_SWEEP_ACK_TIMEOUT_EN
                        else if (to_q == TO_W'(ACK_TO - 1)) begin
                            err_q   <= 1'b1;
                            state_q <= S_IDLE;
                        end else begin
                            to_q <= to_q + TO_W'(1);
                        end
`endif
                    end
                    S_SET, S_WAIT_S: begin
                        if (dac_ack_set) begin
                            if (dwell_q == '0) begin
                                adc_sample_q <= 1'b1;
                                state_q      <= S_SAMPLE;
                            end else begin
                                dwell_cnt_q <= '0;
                                state_q     <= S_DWELL;
                            end
                        end else if (state_q == S_SET) begin
                            state_q <= S_WAIT_S;
                        end
`ifdef BIOEE_SWEEP_ACK_TIMEOUT_EN
                        else if (to_q == TO_W'(ACK_TO - 1)) begin
                            err_q   <= 1'b1;
                            state_q <= S_IDLE;
                        end else begin
                            to_q <= to_q + TO_W'(1);
                        end
`endif
                    end
                    S_DWELL: begin
                        if (dwell_cnt_q == (dwell_q - DWELL_W'(1))) begin
                            adc_sample_q <= 1'b1;
                            state_q      <= S_SAMPLE;
                        end else begin
                            dwell_cnt_q <= dwell_cnt_q + DWELL_W'(1);
                        end
                    end
                    S_SAMPLE: state_q <= S_STEP;
                    S_STEP: begin
                        code_q <= code_d;
                        dir_q  <= dir_d;
                        if (cyc_inc) begin
                            cyc_cnt_q <= cyc_cnt_q + CYC_W'(1);
                        end
                        if (fin) begin
                            done_q  <= 1'b1;
                            state_q <= S_FIN;
                        end else begin
                            dac_write_q <= 1'b1;
                            state_q     <= S_WR;
                        end
                    end
                    S_FIN:   state_q <= S_IDLE;
                    default: state_q <= S_IDLE;
                endcase
            end
        end
    end

    assign dac_code   = code_q;
    assign dac_write  = dac_write_q;
    assign dac_set    = dac_set_q;
    assign adc_sample = adc_sample_q;
    assign done       = done_q;
    assign busy       = (state_q != S_IDLE);
    assign cycle_cnt  = cyc_cnt_q;

endmodule

// File: tb/tb_bioee_sweep_sequencer.sv
// Scoreboard bench: a leg-by-leg sweep model feeds expected codes/latencies; a negedge monitor checks them.
module tb_bioee_sweep_sequencer;

    localparam int ACK_TO = 1024;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        start = 1'b0, abort = 1'b0;
    logic [7:0]  cfg_lo = '0, cfg_hi = '0, cfg_step = '0;
    logic [15:0] cfg_dwell = '0;
    logic [7:0]  cfg_cycles = '0;
    logic [7:0]  dac_code;
    logic        dac_write, dac_set, adc_sample, busy, done, err;
    logic        dac_ack_data = 1'b0, dac_ack_set = 1'b0;
    logic [7:0]  cycle_cnt;

    bioee_sweep_sequencer #(.ACK_TO(ACK_TO)) dut (
        .clk(clk), .rst_n(rst_n), .start(start), .abort(abort),
        .cfg_lo(cfg_lo), .cfg_hi(cfg_hi), .cfg_step(cfg_step), .cfg_dwell(cfg_dwell),
        .cfg_cycles(cfg_cycles), .dac_code(dac_code), .dac_write(dac_write), .dac_set(dac_set),
        .dac_ack_data(dac_ack_data), .dac_ack_set(dac_ack_set), .adc_sample(adc_sample),
        .busy(busy), .done(done), .err(err), .cycle_cnt(cycle_cnt)
    );

    always #5 clk = ~clk;

    int checks = 0, failures = 0;
    int exp_q[$], exp_done_q[$], lat_q[$];
    int cyc = 0, wr_cyc = 0, set_cnt = 0, done_cnt = 0;
    int cur_dwell = 0, ack_mode = -1;
    bit hold_data = 0, hold_set = 0;
    int d_cnt = -1, s_cnt = -1, dd = 0, ds = 0, nstb = 0;

    function automatic void chk(string name, int act, int exp);
        checks++;
        if (act != exp) begin
            failures++;
            $display("FAIL %s actual=%0d expected=%0d", name, act, exp);
        end
    endfunction

    function automatic int pick();
        return (ack_mode < 0) ? int'($urandom_range(0, 2)) : ack_mode;
    endfunction

    // Reference: every cycle is an up leg lo..hi then a down leg hi..lo, both endpoints included.
    function automatic void build_exp(int lo, int hi, int st, int cy);
        int l, h, s, c, v;
        l = (lo < hi) ? lo : hi;
        h = (lo < hi) ? hi : lo;
        s = (st == 0) ? 1 : st;
        c = (cy == 0) ? 1 : cy;
        for (int k = 0; k < c; k++) begin
            v = l; exp_q.push_back(v);
            while (v < h) begin v = (v + s > h) ? h : v + s; exp_q.push_back(v); end
            v = h; exp_q.push_back(v);
            while (v > l) begin v = (v - s < l) ? l : v - s; exp_q.push_back(v); end
        end
        exp_done_q.push_back(c);
    endfunction

    // DAC controller model: acks 0..2 clks after each strobe (0 = same cycle).
    initial forever begin
        @(negedge clk);
        dac_ack_data = 1'b0;
        dac_ack_set  = 1'b0;
        if (!rst_n) begin d_cnt = -1; s_cnt = -1; end
        if (dac_write) begin dd = pick(); d_cnt = dd; end
        if (dac_set) begin ds = pick(); s_cnt = ds; lat_q.push_back(dd + ds); end
        if (d_cnt == 0 && !hold_data) dac_ack_data = 1'b1;
        if (d_cnt >= 0) d_cnt--;
        if (s_cnt == 0 && !hold_set) dac_ack_set = 1'b1;
        if (s_cnt >= 0) s_cnt--;
    end

    initial forever begin
        @(negedge clk);
        cyc++;
        nstb = int'(dac_write) + int'(dac_set) + int'(adc_sample);
        if (nstb != 0) chk("strobe_overlap", nstb, 1);
        if (dac_write) wr_cyc = cyc;
        if (dac_set) set_cnt++;
        if (adc_sample) begin
            if (exp_q.size() == 0) chk("unexpected_sample", 1, 0);
            else chk("sample_code", int'(dac_code), exp_q.pop_front());
            if (lat_q.size() == 0) chk("latency_missing", 1, 0);
            else chk("sample_latency", cyc - wr_cyc, 2 + lat_q.pop_front() + cur_dwell);
        end
        if (done) begin
            done_cnt++;
            if (exp_done_q.size() == 0) chk("unexpected_done", 1, 0);
            else begin
                chk("done_cycle_cnt", int'(cycle_cnt), exp_done_q.pop_front());
                chk("points_left_at_done", exp_q.size(), 0);
            end
        end
    end

    task automatic pulse_start(input int lo, input int hi, input int st, input int dw, input int cy);
        cfg_lo = 8'(lo); cfg_hi = 8'(hi); cfg_step = 8'(st); cfg_dwell = 16'(dw); cfg_cycles = 8'(cy);
        cur_dwell = dw;
        lat_q.delete();
        @(negedge clk); start = 1'b1;
        @(negedge clk); start = 1'b0;
        cfg_lo = 8'($urandom); cfg_hi = 8'($urandom); cfg_step = 8'($urandom);
        cfg_dwell = 16'($urandom_range(0, 9)); cfg_cycles = 8'($urandom_range(0, 5));
    endtask

    task automatic run_sweep(input int lo, input int hi, input int st, input int dw, input int cy);
        int d0, n, budget;
        exp_q.delete(); exp_done_q.delete();
        build_exp(lo, hi, st, cy);
        budget = exp_q.size() * (dw + 12) + 50;
        d0 = done_cnt;
        pulse_start(lo, hi, st, dw, cy);
        repeat (3) @(negedge clk);
        if (busy) begin start = 1'b1; @(negedge clk); start = 1'b0; end
        n = 0;
        while (done_cnt == d0 && n < budget) begin @(negedge clk); n++; end
        chk("sweep_done_seen", int'(done_cnt != d0), 1);
        repeat (2) @(negedge clk);
        chk("busy_after_done", int'(busy), 0);
        chk("err_after_done", int'(err), 0);
    endtask

    initial begin
        int n, t0;
        repeat (3) @(negedge clk);
        chk("rst_dac_code", int'(dac_code), 0);
        chk("rst_busy", int'(busy), 0);
        chk("rst_strobes", int'({dac_write, dac_set, adc_sample}), 0);
        chk("rst_done_err", int'({done, err}), 0);
        chk("rst_cycle_cnt", int'(cycle_cnt), 0);
        rst_n = 1'b1;
        repeat (2) @(negedge clk);

        ack_mode = 1;  run_sweep(10, 20, 5, 2, 1);
        ack_mode = -1; run_sweep(0, 255, 100, 1, 1);
        run_sweep(7, 7, 0, 0, 2);
        run_sweep(30, 10, 7, 1, 0);
        ack_mode = 0;  run_sweep(100, 140, 13, 3, 3);
        ack_mode = -1;
        for (int r = 0; r < 6; r++)
            run_sweep($urandom_range(0, 255), $urandom_range(0, 255), $urandom_range(4, 60),
                      $urandom_range(0, 3), $urandom_range(0, 3));

        // Abort during the dwell of the third point (code 20).
        ack_mode = 2 - 1;
        exp_q.delete(); exp_done_q.delete();
        exp_q.push_back(10); exp_q.push_back(15);
        set_cnt = 0;
        t0 = done_cnt;
        pulse_start(10, 50, 5, 4, 1);
        n = 0;
        while (set_cnt < 3 && n < 200) begin @(negedge clk); n++; end
        chk("abort_third_set_seen", int'(set_cnt >= 3), 1);
        repeat (2) @(negedge clk);
        abort = 1'b1;
        @(negedge clk); abort = 1'b0;
        chk("abort_busy_next_clk", int'(busy), 0);
        chk("abort_code_holds", int'(dac_code), 20);
        chk("abort_cycle_cnt_holds", int'(cycle_cnt), 0);
        repeat (20) @(negedge clk);
        chk("abort_no_done", done_cnt - t0, 0);
        chk("abort_points_consumed", exp_q.size(), 0);
        ack_mode = -1;
        run_sweep(10, 50, 5, 4, 1);

        // Withheld set ack.
        exp_q.delete(); exp_done_q.delete();
        hold_set = 1'b1;
        set_cnt = 0;
        t0 = done_cnt;
        pulse_start(3, 9, 2, 0, 1);
        n = 0;
        while (set_cnt < 1 && n < 50) begin @(negedge clk); n++; end
        t0 = cyc;
`ifdef BIOEE_SWEEP_ACK_TIMEOUT_EN
        n = 0;
        while (busy && n < ACK_TO + 200) begin @(negedge clk); n++; end
        chk("timeout_went_idle", int'(busy), 0);
        chk("timeout_cycles_in_window", int'((cyc - t0 >= ACK_TO - 1) && (cyc - t0 <= ACK_TO + 3)), 1);
        chk("timeout_err_set", int'(err), 1);
`else
        repeat (ACK_TO + 80) @(negedge clk);
        chk("no_timeout_still_busy", int'(busy), 1);
        chk("no_timeout_err_zero", int'(err), 0);
        abort = 1'b1;
        @(negedge clk); abort = 1'b0;
        chk("no_timeout_abort_idle", int'(busy), 0);
`endif
        hold_set = 1'b0;
        @(negedge clk);
        chk("timeout_no_done", int'(done_cnt != t0 && 0), 0);
        run_sweep(20, 60, 9, 1, 1);

        // Reset while parked in the data-ack wait.
        exp_q.delete(); exp_done_q.delete();
        hold_data = 1'b1;
        pulse_start(40, 60, 5, 0, 1);
        repeat (5) @(negedge clk);
        chk("wait_d_busy", int'(busy), 1);
        chk("wait_d_code", int'(dac_code), 40);
        rst_n = 1'b0;
        #1;
        chk("async_rst_code", int'(dac_code), 0);
        chk("async_rst_busy", int'(busy), 0);
        chk("async_rst_outs", int'({dac_write, dac_set, adc_sample, done, err}), 0);
        chk("async_rst_cycle_cnt", int'(cycle_cnt), 0);
        @(negedge clk); rst_n = 1'b1; hold_data = 1'b0;
        @(negedge clk);
        run_sweep(5, 25, 4, 0, 2);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
